// File: rtl/innerproduct_pkg.sv
// Shared definitions for the streaming inner-product engine.
//   state_t  : engine FSM states (ACCUM collects features, HOLD presents a result)
//   prod_w   : width of one feature x weight product
//   sat_add  : clamped addition, evaluated in 64-bit and limited to an acc_w-bit range
//   *_DEF    : default parameter values used by the engine and its lanes
package innerproduct_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int NFEAT_DEF  = 81;
    localparam int NCLASS_DEF = 10;
    localparam int X_W_DEF    = 7;
    localparam int TH_W_DEF   = 16;
    localparam int ACC_W_DEF  = 32;

    // Unsigned feature gets one extra zero bit so it can enter a signed multiply.
    function automatic int prod_w(input int x_w, input int th_w);
        return x_w + 1 + th_w;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 acc_w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One class lane of the inner-product engine: weight register file,
// feature x weight multiplier and wrapping/saturating accumulator.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears weights and accumulator)
//   we/waddr/wdata: weight write port (address is range-checked by the parent)
//   raddr, x      : feature index and unsigned feature value of the current cycle
//   acc_en        : add the current product into the accumulator
//   clear         : zero the accumulator (end of sample)
//   sum           : accumulator plus current product, i.e. the would-be next sum
module mac_lane
    import innerproduct_pkg::*;
#(
    parameter int NFEAT  = NFEAT_DEF,
    parameter int X_W    = X_W_DEF,
    parameter int TH_W   = TH_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SAT    = 0,
    parameter int FEAT_W = $clog2(NFEAT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [FEAT_W-1:0]       waddr,
    input  logic [TH_W-1:0]         wdata,
    input  logic [FEAT_W-1:0]       raddr,
    input  logic [X_W-1:0]          x,
    input  logic                    acc_en,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] sum
);

    localparam int PW = prod_w(X_W, TH_W);

    logic signed [TH_W-1:0]  theta [NFEAT];
    logic signed [ACC_W-1:0] acc;
    logic signed [X_W:0]     xs;
    logic signed [PW-1:0]    prod;

    // The add is done in 64 bits so the product is never truncated before
    // saturation decides; wrapping simply keeps the low ACC_W bits.
    function automatic logic signed [ACC_W-1:0] acc_update(input logic signed [ACC_W-1:0] a,
                                                           input logic signed [PW-1:0]    p);
        logic signed [63:0] s;
        if (SAT != 0) s = sat_add(64'(a), 64'(p), ACC_W);
        else          s = 64'(a) + 64'(p);
        return s[ACC_W-1:0];
    endfunction

    always_comb begin
        xs   = {1'b0, x};
        prod = PW'(xs) * PW'(theta[raddr]);
        sum  = acc_update(acc, prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            for (int f = 0; f < NFEAT; f++) theta[f] <= '0;
        end else begin
            if (clear)       acc <= '0;
            else if (acc_en) acc <= sum;
            // A read of this address in the same cycle still sees the old weight.
            if (we) theta[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/innerproduct_stream_mac.sv
// Streaming inner-product engine: one unsigned feature per valid/ready
// handshake is multiplied by NCLASS signed weight vectors and accumulated over
// NFEAT features. The NCLASS sums and their argmax are then held until taken.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_x   : feature stream; in_last is only checked, never used for framing
//   th_we/th_class/th_feat/th_wdata : weight write port, out-of-range writes ignored
//   out_valid/out_ready      : result handshake
//   out_hprime               : packed signed sums, lane k at [k*ACC_W +: ACC_W]
//   out_class                : index of the largest lane, lowest index on ties
//   err_last                 : sticky flag for in_last disagreeing with the feature count
module innerproduct_stream_mac
    import innerproduct_pkg::*;
#(
    parameter int NFEAT  = NFEAT_DEF,
    parameter int NCLASS = NCLASS_DEF,
    parameter int X_W    = X_W_DEF,
    parameter int TH_W   = TH_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SAT    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [X_W-1:0]              in_x,
    input  logic                        in_last,
    input  logic                        th_we,
    input  logic [$clog2(NCLASS)-1:0]   th_class,
    input  logic [$clog2(NFEAT)-1:0]    th_feat,
    input  logic [TH_W-1:0]             th_wdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NCLASS*ACC_W-1:0]     out_hprime,
    output logic [$clog2(NCLASS)-1:0]   out_class,
    output logic                        err_last
);

    localparam int CLS_W  = $clog2(NCLASS);
    localparam int FEAT_W = $clog2(NFEAT);

    state_t                  state;
    logic [FEAT_W-1:0]       count;
    logic                    hs;
    logic                    is_last;
    logic                    feat_ok;
    logic signed [ACC_W-1:0] lane_sum [NCLASS];
    logic signed [ACC_W-1:0] hp       [NCLASS];
    logic signed [ACC_W-1:0] best_val;
    logic [CLS_W-1:0]        best_idx;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign hs        = in_valid & in_ready;
    assign is_last   = (count == FEAT_W'(NFEAT - 1));
    assign feat_ok   = (32'(th_feat) < NFEAT);

    for (genvar k = 0; k < NCLASS; k++) begin : g_lane
        mac_lane #(
            .NFEAT (NFEAT),
            .X_W   (X_W),
            .TH_W  (TH_W),
            .ACC_W (ACC_W),
            .SAT   (SAT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .we     (th_we && feat_ok && (th_class == CLS_W'(k))),
            .waddr  (th_feat),
            .wdata  (th_wdata),
            .raddr  (count),
            .x      (in_x),
            .acc_en (hs && !is_last),
            .clear  (hs && is_last),
            .sum    (lane_sum[k])
        );
    end

    // Argmax over the final sums is taken at the last handshake, so it is
    // registered together with (and always consistent with) out_hprime.
    always_comb begin
        best_val = lane_sum[0];
        best_idx = '0;
        for (int k = 1; k < NCLASS; k++) begin
            if (lane_sum[k] > best_val) begin
                best_val = lane_sum[k];
                best_idx = CLS_W'(k);
            end
        end
    end

    always_comb begin
        out_hprime = '0;
        for (int k = 0; k < NCLASS; k++) out_hprime[k*ACC_W +: ACC_W] = hp[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            count     <= '0;
            err_last  <= 1'b0;
            out_class <= '0;
            for (int k = 0; k < NCLASS; k++) hp[k] <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (hs) begin
                        if (is_last) begin
                            count     <= '0;
                            state     <= HOLD;
                            out_class <= best_idx;
                            for (int k = 0; k < NCLASS; k++) hp[k] <= lane_sum[k];
                            if (!in_last) err_last <= 1'b1;
                        end else begin
                            count <= count + FEAT_W'(1);
                            if (in_last) err_last <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
